// File: rtl/case_7_mul_arbiter.sv
// Round-robin arbiter sharing one external signed multiplier between NUM_REQ requesters.
// Optional macro CASE_7_MUL_ARB_SKID_EN deepens the output buffer to two entries.
module case_7_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 12,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
  output logic [DIN0_WIDTH-1:0]          mul_din0,
  output logic [DIN1_WIDTH-1:0]          mul_din1,
  input  logic [DOUT_WIDTH-1:0]          mul_dout,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DOUT_WIDTH-1:0]          rsp_dout,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic                           busy
);

`ifdef CASE_7_MUL_ARB_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} buf_state_e;
`else
  typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} buf_state_e;
`endif

  buf_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     cand;
  logic [ID_WIDTH-1:0]     win_id;
  logic                    found;
  logic                    can_accept;
  logic                    accept;
  logic                    pop;
  logic [DOUT_WIDTH-1:0]   head_dout_q, head_dout_d;
  logic [ID_WIDTH-1:0]     head_id_q, head_id_d;
`ifdef CASE_7_MUL_ARB_SKID_EN
  logic [DOUT_WIDTH-1:0]   tail_dout_q, tail_dout_d;
  logic [ID_WIDTH-1:0]     tail_id_q, tail_id_d;
`endif

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // Grants are withheld while reset is asserted so no handshake is lost to the reset.
`ifdef CASE_7_MUL_ARB_SKID_EN
  assign can_accept = (state_q != TWO) && !ap_rst;
`else
  assign can_accept = ((state_q == EMPTY) || rsp_ready) && !ap_rst;
`endif

  assign accept    = found && can_accept;
  assign rsp_valid = (state_q != EMPTY);
  assign busy      = (state_q != EMPTY);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_dout  = head_dout_q;
  assign rsp_id    = head_id_q;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && (win_id == ID_WIDTH'(i))) begin
        req_ready[i] = can_accept;
        mul_din0     = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        mul_din1     = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (win_id == ID_WIDTH'(NUM_REQ - 1)) ptr_d = '0;
      else                                  ptr_d = win_id + ID_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
`ifdef CASE_7_MUL_ARB_SKID_EN
      ONE: begin
        if (accept && !pop)      state_d = TWO;
        else if (!accept && pop) state_d = EMPTY;
      end
      TWO: if (pop) state_d = ONE;
`else
      ONE: if (pop && !accept) state_d = EMPTY;
`endif
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    head_dout_d = head_dout_q;
    head_id_d   = head_id_q;
`ifdef CASE_7_MUL_ARB_SKID_EN
    tail_dout_d = tail_dout_q;
    tail_id_d   = tail_id_q;
    // A push lands in the head when the head is free (or leaving), otherwise in the tail.
    if (accept && ((state_q == EMPTY) || pop)) begin
      head_dout_d = mul_dout;
      head_id_d   = win_id;
    end else if (accept) begin
      tail_dout_d = mul_dout;
      tail_id_d   = win_id;
    end else if (pop && (state_q == TWO)) begin
      head_dout_d = tail_dout_q;
      head_id_d   = tail_id_q;
    end
`else
    if (accept) begin
      head_dout_d = mul_dout;
      head_id_d   = win_id;
    end
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      head_dout_q <= '0;
      head_id_q   <= '0;
`ifdef CASE_7_MUL_ARB_SKID_EN
      tail_dout_q <= '0;
      tail_id_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      head_dout_q <= head_dout_d;
      head_id_q   <= head_id_d;
`ifdef CASE_7_MUL_ARB_SKID_EN
      tail_dout_q <= tail_dout_d;
      tail_id_q   <= tail_id_d;
`endif
    end
  end

endmodule
